keypad_8bit: RTL

KEYPAD_8BIT -- requirements
Module: keypad_8bit

---
 rtl/keypad_8bit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/keypad_8bit.sv
// rtl/keypad_8bit.sv - 4x4 keypad scanner with debounce and 3-digit decimal entry
// Optional auto-repeat of held digit keys: define KEYPAD_AUTOREPEAT_EN.
module keypad_8bit #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [7:0] value,
  output logic       valid,
  output logic [1:0] digit_cnt
);

  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [DW-1:0] deb_cnt;
  logic [3:0]    pat;
  logic [7:0]    acc;
  logic          tick;
  logic [1:0]    r_idx;
  logic [1:0]    c_idx;
  logic [3:0]    code;
  logic [11:0]   acc_next;
  logic          accept;
  logic          repeat_fire;

  function automatic logic [3:0] map_code(input logic [3:0] idx);
    case (idx)
      4'd0:  map_code = 4'd1;
      4'd1:  map_code = 4'd2;
      4'd2:  map_code = 4'd3;
      4'd3:  map_code = 4'd10;
      4'd4:  map_code = 4'd4;
      4'd5:  map_code = 4'd5;
      4'd6:  map_code = 4'd6;
      4'd7:  map_code = 4'd11;
      4'd8:  map_code = 4'd7;
      4'd9:  map_code = 4'd8;
      4'd10: map_code = 4'd9;
      4'd11: map_code = 4'd12;
      4'd12: map_code = 4'd14;
      4'd13: map_code = 4'd0;
      4'd14: map_code = 4'd15;
      default: map_code = 4'd13;
    endcase
  endfunction

  assign tick = ce && (presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       presc <= '0;
    else if (ce)   presc <= tick ? '0 : presc + 1'b1;
  end

  always_comb begin
    r_idx = 2'd3;
    case (row)
      4'b1110: r_idx = 2'd0;
      4'b1101: r_idx = 2'd1;
      4'b1011: r_idx = 2'd2;
      default: r_idx = 2'd3;
    endcase
    // lowest-index low column wins when several are pressed
    c_idx = 2'd3;
    if (!col[2]) c_idx = 2'd2;
    if (!col[1]) c_idx = 2'd1;
    if (!col[0]) c_idx = 2'd0;
  end

  assign code     = map_code({r_idx, c_idx});
  assign acc_next = 12'(acc) * 12'd10 + 12'(code);
  assign accept   = repeat_fire ||
                    (tick && state == S_DEB && col == pat && deb_cnt == DW'(DEBOUNCE - 1));

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT + 1);
  logic [RW-1:0] rep_cnt;
  logic          rep_ok;

  assign rep_ok      = state == S_HELD && col != 4'hF && code <= 4'd9;
  assign repeat_fire = tick && rep_ok && rep_cnt == RW'(REPEAT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rep_cnt <= '0;
    else if (tick)    rep_cnt <= (rep_ok && !repeat_fire) ? rep_cnt + 1'b1 : '0;
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_SCAN;
      row        <= 4'b1110;
      pat        <= 4'hF;
      deb_cnt    <= '0;
      key_code   <= 4'd0;
      key_strobe <= 1'b0;
      value      <= 8'd0;
      valid      <= 1'b0;
      digit_cnt  <= 2'd0;
      acc        <= 8'd0;
    end else begin
      key_strobe <= 1'b0;
      valid      <= 1'b0;
      if (tick) begin
        case (state)
          S_SCAN: begin
            if (col != 4'hF) begin
              pat     <= col;
              deb_cnt <= '0;
              state   <= S_DEB;
            end else begin
              row <= {row[2:0], row[3]};
            end
          end
          S_DEB: begin
            if (col != pat)                          state   <= S_SCAN;
            else if (deb_cnt == DW'(DEBOUNCE - 1))   state   <= S_HELD;
            else                                     deb_cnt <= deb_cnt + 1'b1;
          end
          S_HELD: begin
            if (col == 4'hF) begin
              deb_cnt <= '0;
              state   <= S_REL;
            end
          end
          default: begin
            if (col != 4'hF)                         state   <= S_HELD;
            else if (deb_cnt == DW'(DEBOUNCE - 1))   state   <= S_SCAN;
            else                                     deb_cnt <= deb_cnt + 1'b1;
          end
        endcase
      end
      if (accept) begin
        key_strobe <= 1'b1;
        key_code   <= code;
        if (code <= 4'd9) begin
          if (digit_cnt != 2'd3) begin
            acc       <= (acc_next > 12'd255) ? 8'hFF : acc_next[7:0];
            digit_cnt <= digit_cnt + 1'b1;
          end
        end else if (code == 4'd15) begin
          value     <= acc;
          valid     <= 1'b1;
          acc       <= 8'd0;
          digit_cnt <= 2'd0;
        end else if (code == 4'd14) begin
          acc       <= 8'd0;
          digit_cnt <= 2'd0;
        end
      end
    end
  end

endmodule
